// File: rtl/dilithium_vy_pkg.sv
// dilithium_vy_pkg: shared types, constants and operand sizing for the verify sequencer
package dilithium_vy_pkg;

    typedef enum logic [2:0] {SEG_RHO, SEG_C, SEG_Z, SEG_T1, SEG_MLEN, SEG_MSG, SEG_H} seg_e;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_STREAM, ST_RESULT, ST_DONE} state_e;

    localparam logic [1:0] MODE_VERIFY = 2'd1;

    // MLEN and MSG are sized at run time; they report one word here
    function automatic int unsigned seg_words(seg_e s, int unsigned lvl, int unsigned w);
        int unsigned bits;
        bits = (s == SEG_RHO || s == SEG_C) ? 256 :
               s == SEG_Z  ? (lvl == 2 ? 18432 : lvl == 3 ? 25600 : 35840) :
               s == SEG_T1 ? (lvl == 2 ? 10240 : lvl == 3 ? 15360 : 20480) :
               s == SEG_H  ? (lvl == 2 ? 672 : lvl == 3 ? 488 : 664) : w;
        return (bits + w - 1) / w;
    endfunction

endpackage

// File: rtl/vy_word_fifo.sv
// vy_word_fifo: 2-deep word FIFO between the operand fetch and the core input
module vy_word_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);

    logic [W-1:0] mem_q [2];
    logic         wp_q, rp_q;
    logic [1:0]   cnt_q;

    assign data_o  = mem_q[rp_q];
    assign empty_o = cnt_q == 2'd0;
    assign full_o  = cnt_q == 2'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) mem_q[wp_q] <= data_i;
            wp_q  <= wp_q ^ push_i;
            rp_q  <= rp_q ^ pop_i;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

endmodule

// File: rtl/dilithium_vy_sequencer.sv
// dilithium_vy_sequencer: fetches verify operands from RAM, streams them to the core
// in rho,c,z,t1,mlen,msg,h order and collects the accept/reject result word.
module dilithium_vy_sequencer
    import dilithium_vy_pkg::*;
#(
    parameter int W         = 64,
    parameter int SEC_LEVEL = 2,
    parameter int ADDR_W    = 12,
    parameter int MLEN_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [MLEN_W-1:0] msg_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [W-1:0]      mem_rd_data,
    output logic              core_start,
    output logic [1:0]        core_mode,
    output logic              core_valid_i,
    output logic [W-1:0]      core_data_i,
    input  logic              core_ready_i,
    input  logic              core_valid_o,
    input  logic [W-1:0]      core_data_o,
    output logic              core_ready_o,
    output logic              busy,
    output logic              done,
    output logic              accept
);

    localparam int CW = 32;
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] RHO_WORDS = CW'(seg_words(SEG_RHO, SEC_LEVEL, W));
    localparam logic [CW-1:0] FIX_WORDS = CW'(seg_words(SEG_RHO, SEC_LEVEL, W) + seg_words(SEG_C, SEC_LEVEL, W)
                                            + seg_words(SEG_Z, SEC_LEVEL, W) + seg_words(SEG_T1, SEC_LEVEL, W)
                                            + seg_words(SEG_H, SEC_LEVEL, W)) + ONE;

    state_e            state_q;
    seg_e              rd_seg_q, nxt_seg;
    logic [CW-1:0]     rd_left_q, out_left_q, msg_words_q, go_msg_words, next_len;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [MLEN_W-1:0] msg_len_q;
    logic              fetch_done_q, rd_mem_q, rd_mlen_q;
    logic              fifo_full, fifo_empty, push, pop, issue;
    logic [W-1:0]      push_data;
    logic [2:0]        fill_nxt;

    assign core_mode    = MODE_VERIFY;
    assign core_valid_i = !fifo_empty;
    assign pop          = core_valid_i && core_ready_i;
    assign push         = rd_mem_q || rd_mlen_q;
    assign push_data    = rd_mlen_q ? W'(msg_len_q) : mem_rd_data;
    // occupancy after this cycle's arrival and pop; a new read may only claim a free slot
    assign fill_nxt     = {1'b0, fifo_full, !fifo_empty && !fifo_full} + {2'b0, push} - {2'b0, pop};
    assign issue        = state_q == ST_STREAM && !fetch_done_q && fill_nxt < 3'd2;
    assign mem_rd_en    = issue && rd_seg_q != SEG_MLEN;
    assign mem_addr     = rd_addr_q;
    assign nxt_seg      = seg_e'(rd_seg_q + 3'd1);
    assign next_len     = nxt_seg == SEG_MSG ? msg_words_q : nxt_seg == SEG_MLEN ? ONE :
                          CW'(seg_words(nxt_seg, SEC_LEVEL, W));
    assign go_msg_words = msg_len == '0 ? ONE : (CW'(msg_len) * 8 + CW'(W - 1)) / CW'(W);

    vy_word_fifo #(.W(W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_data),
        .data_o  (core_data_i),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rd_seg_q     <= SEG_RHO;
            rd_left_q    <= '0;
            out_left_q   <= '0;
            msg_words_q  <= '0;
            rd_addr_q    <= '0;
            msg_len_q    <= '0;
            fetch_done_q <= 1'b0;
            rd_mem_q     <= 1'b0;
            rd_mlen_q    <= 1'b0;
            core_start   <= 1'b0;
            core_ready_o <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            accept       <= 1'b0;
        end else begin
            rd_mem_q  <= mem_rd_en;
            rd_mlen_q <= issue && rd_seg_q == SEG_MLEN;
            if (issue) begin
                if (rd_seg_q != SEG_MLEN) rd_addr_q <= rd_addr_q + ADDR_W'(1);
                if (rd_left_q == ONE) begin
                    fetch_done_q <= rd_seg_q == SEG_H;
                    rd_seg_q     <= nxt_seg;
                    rd_left_q    <= next_len;
                end else begin
                    rd_left_q <= rd_left_q - ONE;
                end
            end
            if (pop) out_left_q <= out_left_q - ONE;
            case (state_q)
                ST_IDLE: if (go) begin
                    msg_len_q    <= msg_len;
                    msg_words_q  <= go_msg_words;
                    rd_addr_q    <= base_addr;
                    rd_seg_q     <= SEG_RHO;
                    rd_left_q    <= RHO_WORDS;
                    out_left_q   <= FIX_WORDS + go_msg_words;
                    fetch_done_q <= 1'b0;
                    busy         <= 1'b1;
                    core_start   <= 1'b1;
                    accept       <= 1'b0;
                    state_q      <= ST_START;
                end
                ST_START: begin
                    core_start <= 1'b0;
                    state_q    <= ST_STREAM;
                end
                ST_STREAM: if (pop && out_left_q == ONE) begin
                    core_ready_o <= 1'b1;
                    state_q      <= ST_RESULT;
                end
                ST_RESULT: if (core_valid_o) begin
                    accept       <= core_data_o == '0;
                    core_ready_o <= 1'b0;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dilithium_vy_sequencer.sv
// tb_dilithium_vy_sequencer: randomized runs checked against a segment-level reference model
module tb_dilithium_vy_sequencer;

    localparam int W  = 64;
    localparam int AW = 12;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [MW-1:0] msg_len = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rd_data = '0;
    logic          core_start;
    logic [1:0]    core_mode;
    logic          core_valid_i;
    logic [W-1:0]  core_data_i;
    logic          core_ready_i = 1'b0;
    logic          core_valid_o = 1'b0;
    logic [W-1:0]  core_data_o = '0;
    logic          core_ready_o, busy, done, accept;

    logic [W-1:0]  ram [4096];
    logic [AW-1:0] rd_q [$];
    logic [W-1:0]  exp_d [$];
    logic [AW-1:0] exp_a [$];
    int            h_idx;
    logic [AW-1:0] h_addr;
    int            checks = 0;
    int            errors = 0;

    dilithium_vy_sequencer #(.W(W), .SEC_LEVEL(2), .ADDR_W(AW), .MLEN_W(MW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .base_addr    (base_addr),
        .msg_len      (msg_len),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .core_start   (core_start),
        .core_mode    (core_mode),
        .core_valid_i (core_valid_i),
        .core_data_i  (core_data_i),
        .core_ready_i (core_ready_i),
        .core_valid_o (core_valid_o),
        .core_data_o  (core_data_o),
        .core_ready_o (core_ready_o),
        .busy         (busy),
        .done         (done),
        .accept       (accept)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= ram[mem_addr];
            rd_q.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // level-2, 64-bit operand stream built segment by segment from the RAM contents
    task automatic build(input logic [AW-1:0] base, input logic [MW-1:0] len);
        int bits [7] = '{256, 256, 18432, 10240, 0, 0, 672};
        int off = 0;
        int n;
        logic [AW-1:0] a;
        exp_d.delete();
        exp_a.delete();
        for (int s = 0; s < 7; s++) begin
            n = s == 4 ? 1 : s == 5 ? (len == 0 ? 1 : (int'(len) * 8 + 63) / 64) : (bits[s] + 63) / 64;
            if (s == 6) begin
                h_idx  = off;
                h_addr = AW'(int'(base) + off);
            end
            for (int i = 0; i < n; i++) begin
                if (s == 4) exp_d.push_back(64'(len));
                else begin
                    a = AW'(int'(base) + off);
                    exp_a.push_back(a);
                    exp_d.push_back(ram[a]);
                    off++;
                end
            end
        end
    endtask

    task automatic run(input string tag, input logic [AW-1:0] base, input logic [MW-1:0] len,
                       input int mode, input logic res, input bit mid_go, input int rst_at);
        logic [W-1:0] rx [$];
        logic [W-1:0] held = '0;
        bit pend = 0;
        bit got_done = 0;
        int stall_err = 0;
        int data_err = 0;
        int addr_err = 0;
        int cyc = 0;
        build(base, len);
        rd_q.delete();
        @(negedge clk);
        go = 1'b1;
        base_addr = base;
        msg_len = len;
        @(negedge clk);
        go = 1'b0;
        base_addr = AW'($urandom);
        msg_len = MW'($urandom);
        while (!got_done && cyc < 4000) begin
            core_ready_i = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
            core_valid_o = core_ready_o;
            core_data_o  = W'(res);
            #1;
            if (pend && (!core_valid_i || core_data_i !== held)) stall_err++;
            pend = core_valid_i && !core_ready_i;
            held = core_data_i;
            if (core_valid_i && core_ready_i) rx.push_back(core_data_i);
            if (done) got_done = 1;
            go = mid_go && rx.size() == 50;
            if (rst_at > 0 && rx.size() == rst_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_ctl"}, 64'({busy, done, core_start, core_valid_i, mem_rd_en, core_ready_o, accept}), 64'd0);
                check({tag, "_rst_bus"}, {52'd0, mem_addr} | core_data_i, 64'd0);
                go = 1'b0;
                core_valid_o = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        core_valid_o = 1'b0;
        go = 1'b0;
        for (int i = 0; i < exp_d.size() && i < rx.size(); i++) if (rx[i] !== exp_d[i]) data_err++;
        for (int i = 0; i < exp_a.size() && i < rd_q.size(); i++) if (rd_q[i] !== exp_a[i]) addr_err++;
        check({tag, "_done"}, 64'(got_done), 64'd1);
        check({tag, "_words"}, 64'(rx.size()), 64'(exp_d.size()));
        check({tag, "_data_err"}, 64'(data_err), 64'd0);
        check({tag, "_reads"}, 64'(rd_q.size()), 64'(exp_a.size()));
        check({tag, "_addr_err"}, 64'(addr_err), 64'd0);
        check({tag, "_mlen_word"}, rx.size() > 456 ? rx[456] : '1, 64'(len));
        check({tag, "_h_addr"}, rd_q.size() > h_idx ? 64'(rd_q[h_idx]) : '1, 64'(h_addr));
        check({tag, "_stall"}, 64'(stall_err), 64'd0);
        check({tag, "_accept"}, 64'(accept), 64'(!res));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctl", 64'({busy, done, core_start, core_valid_i, mem_rd_en, core_ready_o, accept}), 64'd0);
        check("core_mode", 64'(core_mode), 64'd1);
        rst_n = 1'b1;
        run("base", 12'd0, 16'd33, 0, 1'b0, 1'b0, 0);
        check("base_total", 64'(exp_d.size()), 64'd473);
        run("toggle", 12'd0, 16'd33, 1, 1'b0, 1'b0, 0);
        run("len0", 12'd0, 16'd0, 2, 1'b1, 1'b0, 0);
        run("wrap", 12'd4090, 16'd33, 2, 1'b0, 1'b0, 0);
        run("midgo", 12'd20, 16'd33, 0, 1'b0, 1'b1, 0);
        run("rst", 12'd300, 16'd33, 0, 1'b0, 1'b0, 100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run("after", 12'd100, MW'($urandom_range(0, 200)), 2, 1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++)
            run("rand", AW'($urandom), MW'($urandom_range(0, 300)), 2, 1'($urandom_range(0, 1)), 1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dilithium_vy_sequencer.md
Name: dilithium_vy_sequencer

Overview:
Autonomous operand sequencer for a verify (mode 2'd1) run on the dilithium core. It fetches the verify operands from a word-addressable operand RAM and streams them into the core's valid/ready input in the fixed high-perf order: rho, c, z, t1, mlen, msg, h. It then collects the single result word and reports accept or reject. It sits between the host register file / operand RAM and the core, replacing host-driven word pushing.

Parameters:
W, 64, datapath word width (32 low-perf, 64 high-perf)
SEC_LEVEL, 2, Dilithium level 2/3/5; selects z/t1/h sizes
ADDR_W, 12, operand RAM word-address width
MLEN_W, 16, width of the message byte-length field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
go  in  1  single-cycle request to start a verify run
base_addr  in  ADDR_W  RAM word address of rho; sampled on an accepted go
msg_len  in  MLEN_W  message length in bytes; sampled on an accepted go
mem_rd_en  out  1  RAM read strobe
mem_addr  out  ADDR_W  RAM read address
mem_rd_data  in  W  RAM read data, valid exactly 1 cycle after mem_rd_en
core_start  out  1  start pulse to the core
core_mode  out  2  constant 2'd1 (verify)
core_valid_i  out  1  data_i valid toward the core
core_data_i  out  W  operand word
core_ready_i  in  1  core accepts core_data_i this cycle
core_valid_o  in  1  result word valid
core_data_o  in  W  result word (0 = accept, 1 = reject)
core_ready_o  out  1  sequencer ready for the result
busy  out  1  run in progress
done  out  1  1-cycle pulse at end of run
accept  out  1  result of the last run, held until the next accepted go

Behaviour:
- Reset: all outputs 0 (core_mode is constant 2'd1). FSM goes to IDLE, FIFO is emptied, in-flight read is dropped.
- Word counts are ceil(bits/W). Sizes in bits: rho 256, c 256, z 18432/25600/35840, t1 10240/15360/20480, h 672/488/664.
- msg words = max(1, ceil(msg_len*8/W)). msg_len=0 still sends one word.
- mlen segment: one word, msg_len zero-extended to W, generated internally with no RAM read.
- RAM layout is contiguous words from base_addr: rho, c, z, t1, msg (padded to whole words), h. Address arithmetic wraps modulo 2^ADDR_W.
- FSM states and transitions:
  - IDLE: go latches base_addr and msg_len, sets busy, goes to START.
  - START: core_start=1 for exactly one cycle, then STREAM.
  - STREAM: segment counter walks RHO→C→Z→T1→MLEN→MSG→H; word counter per segment. On the last h word accepted, goes to RESULT.
  - RESULT: core_ready_o=1. On core_valid_o, accept <= (core_data_o==0), then DONE.
  - DONE: done=1 for one cycle, busy falls, returns to IDLE.
- Fetch path: 2-entry word FIFO feeds the core.
  - A RAM read is issued only when FIFO occupancy plus in-flight reads is below 2, so reads never overrun.
  - The MLEN word is pushed into the FIFO in read order, with no RAM access.
  - core_valid_i = FIFO not empty; core_data_i = FIFO head; pop on core_valid_i & core_ready_i.
  - Simultaneous push and pop keeps occupancy.
- Full throughput: with core_ready_i held high, one word is accepted per cycle after a 2-cycle fill.
- core_valid_i never drops while data is pending. Data is stable while valid & !ready.
- go while busy is ignored; latched params stay unchanged.
- Async reset mid-run aborts the run immediately with no done pulse. The core must be re-reset by its owner.

Decomposition:
- Package dilithium_vy_pkg holds:
  - segment enum {SEG_RHO, SEG_C, SEG_Z, SEG_T1, SEG_MLEN, SEG_MSG, SEG_H}
  - FSM state enum
  - function returning words per fixed segment given SEC_LEVEL and W
  - MODE_VERIFY = 2'd1 constant
- One sub-module, vy_word_fifo: 2-deep, W-wide, push/pop/empty/full, async active-low reset.

Test Plan:
- SEC_LEVEL=2, W=64, msg_len=33, base_addr=0, ready always 1:
  - core receives 473 words (4+4+288+160+1+5+11); word 456 = 64'd33.
  - RAM reads = 472; first h read at address 461.
  - result 0 → done pulse, accept=1.
- Same run with core_ready_i toggling 1/0 each cycle: identical 473-word sequence, no drop or duplicate, data stable while stalled.
- msg_len=0: exactly 1 msg word sent, total 469 words. Core returns 1 → accept=0.
- base_addr=4090 (ADDR_W=12): addresses wrap 4095→0, data order intact.
- go pulsed again mid-stream: ignored; run completes with the original msg_len.
- rst_n low at word 100: all outputs 0 within the same cycle. The next go restarts from rho at the new base_addr.
